// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the memory it feeds.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_FINISH,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid marks the byte
// that completes a word, with the full word presented combinationally alongside it.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  // Lane counter and three-byte shift register (oldest byte ends up in bits 7:0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= '0;
      shreg <= '0;
    end else if (clear) begin
      lane  <= '0;
    end else if (byte_valid) begin
      lane  <= lane + 2'd1;
      shreg <= {byte_data, shreg[23:8]};
    end
  end

  // Fourth byte completes the word: it lands in the top lane
  always_comb begin
    word_valid = byte_valid && (lane == 2'(WORD_BYTES - 1));
    word       = {byte_data, shreg};
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-image loader: length header, then N little-endian words written to the
// instruction memory at byte addresses 0,4,8,... while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned LEN_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t             state, state_next;
  logic [LEN_W-1:0]   n_words;
  logic [LEN_W-1:0]   word_idx;
  logic [LEN_W-1:0]   idx_next;
  logic               take;
  logic               hdr_zero;
  logic               hdr_big;
  logic               last_word;
  logic               pk_valid;
  logic [31:0]        pk_word;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (reset),
    .clear      (state == ST_LEN),
    .byte_valid (take && (state == ST_LOAD)),
    .byte_data  (rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // Handshake, header classification and status outputs
  always_comb begin
    rx_ready  = (state == ST_LEN) || (state == ST_LOAD);
    take      = rx_valid && rx_ready;
    hdr_zero  = (rx_data == 8'd0);
    hdr_big   = ({24'd0, rx_data} > 32'(DEPTH));
    idx_next  = word_idx + LEN_W'(1);
    last_word = (idx_next == n_words);
    busy      = (state == ST_LEN) || (state == ST_LOAD) || (state == ST_FINISH);
    cpu_hold  = busy;
    done      = (state == ST_DONE);
    err       = (state == ST_ERROR);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_LEN;
      ST_LEN: begin
        if (take) begin
          if (hdr_zero)     state_next = ST_DONE;
          else if (hdr_big) state_next = ST_ERROR;
          else              state_next = ST_LOAD;
        end
      end
      ST_LOAD:   if (pk_valid && last_word) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_DONE;
      ST_DONE:   if (start) state_next = ST_LEN;
      ST_ERROR:  if (start) state_next = ST_LEN;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Length latch, word index and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_words  <= '0;
      word_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if ((state == ST_LEN) && take) begin
        n_words  <= LEN_W'(rx_data);
        word_idx <= '0;
      end
      if ((state == ST_LOAD) && pk_valid) begin
        wr_en    <= 1'b1;
        wr_data  <= pk_word;
        wr_addr  <= {{(30 - LEN_W){1'b0}}, word_idx, 2'b00};
        word_idx <= idx_next;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand-written corner cases
// and randomized sessions against an expected-write list built from the image bytes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, wr_en, cpu_hold, busy, done, err;
  logic [31:0] wr_addr, wr_data;

  int n_tests, n_fail;

  imem_loader #(.DEPTH(64), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t obs[$];
  wr_t expq[$];

  // Record every write strobe seen
  always @(negedge clk) if (wr_en) obs.push_back('{wr_addr, wr_data});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    if (gap > 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    cnt = 0;
    while (!rx_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte: rx_ready stuck low got 0 expected 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int cnt;
    cnt = 0;
    while (!(done || err) && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL wait_end: done/err got 0 expected 1");
    end
  endtask

  // Expected writes: word i = little-endian bytes 4i..4i+3, at byte address 4i
  task automatic build_expected(input logic [7:0] img[$], input int n);
    expq.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = 32'(img[4*i]) + (32'(img[4*i+1]) << 8) + (32'(img[4*i+2]) << 16)
        + (32'(img[4*i+3]) << 24);
      expq.push_back('{32'(4 * i), d});
    end
  endtask

  task automatic compare_writes(input string name);
    check({name, "_count"}, 32'(obs.size()), 32'(expq.size()));
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), obs[i].a, expq[i].a);
      check($sformatf("%s_data%0d", name, i), obs[i].d, expq[i].d);
    end
    obs.delete();
  endtask

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  b [8];
    int          nbytes;
    int          gap;
    logic [31:0] w [2];
    int          nwr;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] img[$];
    n_tests = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_flags", {26'd0, rx_ready, cpu_hold, busy, done, err, wr_en}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(rx_ready), 0);

    vecs[0] = '{8'h02, '{8'h93, 8'h06, 8'h30, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00}, 8, 0,
                '{32'h00300693, 32'h00100513}, 2, 1'b1, 1'b0};
    vecs[1] = '{8'h00, '{8{8'h00}}, 0, 0, '{32'h0, 32'h0}, 0, 1'b1, 1'b0};
    vecs[2] = '{8'h41, '{8{8'h00}}, 0, 0, '{32'h0, 32'h0}, 0, 1'b0, 1'b1};
    vecs[3] = '{8'h01, '{8'h63, 8'h86, 8'h94, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0}, 4, 1,
                '{32'h00948663, 32'h0}, 1, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, '{8{8'h00}}, 0, 0, '{32'h0, 32'h0}, 0, 1'b0, 1'b1};
    vecs[5] = '{8'h01, '{8'h00, 8'h00, 8'h00, 8'h80, 8'h0, 8'h0, 8'h0, 8'h0}, 4, 0,
                '{32'h80000000, 32'h0}, 1, 1'b1, 1'b0};

    for (int v = 0; v < 6; v++) begin
      obs.delete();
      pulse_start();
      check($sformatf("v%0d_hold", v), {30'd0, cpu_hold, busy}, 32'h3);
      send_byte(vecs[v].hdr, vecs[v].gap);
      for (int j = 0; j < vecs[v].nbytes; j++) send_byte(vecs[v].b[j], vecs[v].gap);
      wait_end();
      check($sformatf("v%0d_status", v), {30'd0, done, err},
            {30'd0, vecs[v].exp_done, vecs[v].exp_err});
      check($sformatf("v%0d_idle", v), {30'd0, cpu_hold, rx_ready}, 0);
      expq.delete();
      for (int k = 0; k < vecs[v].nwr; k++) expq.push_back('{32'(4 * k), vecs[v].w[k]});
      compare_writes($sformatf("v%0d", v));
    end

    // Last-write / done timing and error recovery
    obs.delete();
    pulse_start();
    check("err_cleared_by_start", {29'd0, err, done, busy}, 32'h1);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    check("finish_wr", {29'd0, wr_en, done, rx_ready}, 32'h4);
    check("finish_data", wr_data, 32'h44332211);
    @(negedge clk);
    check("done_after_wr", {29'd0, wr_en, done, cpu_hold}, 32'h2);
    check("addr_held", wr_addr, 0);
    check("data_held", wr_data, 32'h44332211);
    obs.delete();

    // Reset two bytes into word 1 of a 3-word image
    pulse_start();
    send_byte(8'h03, 0);
    for (int j = 0; j < 6; j++) send_byte(8'(j + 1), 0);
    reset = 1'b1;
    #1;
    check("midrst_outputs", {26'd0, rx_ready, cpu_hold, busy, done, err, wr_en}, 0);
    check("midrst_addr", wr_addr, 0);
    check("midrst_data", wr_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_writes", 32'(obs.size()), 1);
    obs.delete();
    img.delete();
    for (int j = 0; j < 12; j++) img.push_back(8'($urandom));
    pulse_start();
    send_byte(8'h03, 0);
    foreach (img[j]) send_byte(img[j], 0);
    wait_end();
    build_expected(img, 3);
    compare_writes("after_rst");

    // Full-depth load with start pulsed mid-stream
    img.delete();
    for (int j = 0; j < 256; j++) img.push_back(8'($urandom));
    pulse_start();
    send_byte(8'd64, 0);
    for (int j = 0; j < 256; j++) begin
      if (j == 37) begin
        pulse_start();
        check("start_ignored", {30'd0, busy, rx_ready}, 32'h3);
      end
      send_byte(img[j], 0);
    end
    wait_end();
    check("full_done", 32'(done), 1);
    if (obs.size() == 64) check("last_addr", obs[63].a, 32'd252);
    else check("full_count_pre", 32'(obs.size()), 64);
    build_expected(img, 64);
    compare_writes("full");

    // Randomized sessions with random header and valid gaps
    for (int s = 0; s < 8; s++) begin
      int n, hdr;
      obs.delete();
      hdr = (s == 0) ? 0 : (s == 1) ? 65 + int'($urandom_range(0, 100)) : int'($urandom_range(1, 64));
      n = (hdr >= 1 && hdr <= 64) ? hdr : 0;
      img.delete();
      for (int j = 0; j < 4 * n; j++) img.push_back(8'($urandom));
      pulse_start();
      send_byte(8'(hdr), int'($urandom_range(0, 2)));
      foreach (img[j]) send_byte(img[j], int'($urandom_range(0, 2)));
      wait_end();
      check($sformatf("rnd%0d_status", s), {30'd0, done, err},
            (hdr > 64) ? 32'h1 : 32'h2);
      build_expected(img, n);
      compare_writes($sformatf("rnd%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
